merge_readout_ctrl: RTL and testbench

Per-BX sequencer for the 8-input merge readout datapath. It selects the source-memory page for each bunch crossing and holds the merger and address counters in reset between crossings. It releases them for one readout window, counts merged words against the sum of the eight input occupancies, and reports completion. It sits between the BX clock-domain logic (start pulses) and the merge readout datapath.

---
 rtl/merge_readout_ctrl.sv | 167 ++++++++++++++++
 tb/tb_merge_readout_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/merge_readout_ctrl.sv
// merge_readout_ctrl: per-BX sequencer that flushes, releases and monitors the 8-input merge datapath.
// Optional build macro MERGE_RO_TIMEOUT_EN bounds each RUN window to MAX_CYCLES cycles.
module merge_readout_ctrl #(
   parameter int PAGE_BITS    = 2,
   parameter int FLUSH_CYCLES = 2,
   parameter int MAX_CYCLES   = 100,
   parameter int CNT_WIDTH    = 6
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   bx_start,
   input  logic [2:0]             bx_in,
   input  logic [8*CNT_WIDTH-1:0] number_in,
   input  logic                   valid_out,
   output logic                   merge_rst,
   output logic [PAGE_BITS-1:0]   page_out,
   output logic [CNT_WIDTH+2:0]   expected,
   output logic [CNT_WIDTH+2:0]   word_cnt,
   output logic                   busy,
   output logic                   done,
   output logic [2:0]             bx_done,
   output logic                   timeout,
   output logic                   missed_start
);
   localparam int SUM_W = CNT_WIDTH + 3;
   localparam int FC_W  = $clog2(FLUSH_CYCLES + 1);

   if (FLUSH_CYCLES < 1 || MAX_CYCLES < 1) begin : g_bad_cfg
      $error("merge_readout_ctrl: FLUSH_CYCLES and MAX_CYCLES must be at least 1");
   end

   typedef enum logic [1:0] {IDLE, FLUSH, RUN, DONE} state_t;

   state_t               state_q;
   logic [2:0]           bx_reg_q;
   logic [2:0]           bx_done_q;
   logic [PAGE_BITS-1:0] page_q;
   logic [SUM_W-1:0]     expected_q;
   logic [SUM_W-1:0]     word_cnt_q;
   logic [FC_W-1:0]      flush_cnt_q;
   logic                 merge_rst_q;
   logic                 busy_q;
   logic                 done_q;
   logic                 timeout_q;
   logic                 missed_q;
   logic [SUM_W-1:0]     sum_d;
   logic [SUM_W-1:0]     word_cnt_d;

`ifdef MERGE_RO_TIMEOUT_EN
   localparam int RC_W = $clog2(MAX_CYCLES + 1);
   logic [RC_W-1:0] run_cnt_q;
`endif

   // Zero-extended occupancy total; SUM_W bits hold 8 * (2**CNT_WIDTH - 1) without overflow.
   function automatic logic [SUM_W-1:0] occ_sum(input logic [8*CNT_WIDTH-1:0] occ);
      logic [SUM_W-1:0] s;
      s = '0;
      for (int k = 0; k < 8; k++) s = s + SUM_W'(occ[k*CNT_WIDTH +: CNT_WIDTH]);
      return s;
   endfunction

   always_comb begin
      sum_d      = occ_sum(number_in);
      word_cnt_d = word_cnt_q + SUM_W'(valid_out);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         bx_reg_q    <= '0;
         bx_done_q   <= '0;
         page_q      <= '0;
         expected_q  <= '0;
         word_cnt_q  <= '0;
         flush_cnt_q <= '0;
         merge_rst_q <= 1'b1;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         timeout_q   <= 1'b0;
         missed_q    <= 1'b0;
`ifdef MERGE_RO_TIMEOUT_EN
         run_cnt_q   <= '0;
`endif
      end else begin
         done_q    <= 1'b0;
         timeout_q <= 1'b0;
         missed_q  <= 1'b0;
         case (state_q)
            IDLE, DONE: begin
               // The DONE cycle accepts a new crossing exactly like IDLE does.
               if (bx_start) begin
                  state_q     <= FLUSH;
                  bx_reg_q    <= bx_in;
                  page_q      <= bx_in[PAGE_BITS-1:0];
                  word_cnt_q  <= '0;
                  flush_cnt_q <= '0;
                  merge_rst_q <= 1'b1;
                  busy_q      <= 1'b1;
               end else begin
                  state_q     <= IDLE;
                  merge_rst_q <= 1'b1;
                  busy_q      <= 1'b0;
               end
            end
            FLUSH: begin
               if (bx_start) missed_q <= 1'b1;
               if (flush_cnt_q == FC_W'(FLUSH_CYCLES - 1)) begin
                  expected_q <= sum_d;
                  if (sum_d == '0) begin
                     state_q   <= DONE;
                     done_q    <= 1'b1;
                     bx_done_q <= bx_reg_q;
                     busy_q    <= 1'b0;
                  end else begin
                     state_q     <= RUN;
                     merge_rst_q <= 1'b0;
`ifdef MERGE_RO_TIMEOUT_EN
                     run_cnt_q   <= '0;
`endif
                  end
               end else begin
                  flush_cnt_q <= flush_cnt_q + FC_W'(1);
               end
            end
            RUN: begin
               if (bx_start) missed_q <= 1'b1;
               if (valid_out) word_cnt_q <= word_cnt_d;
               if (word_cnt_d == expected_q) begin
                  state_q     <= DONE;
                  done_q      <= 1'b1;
                  bx_done_q   <= bx_reg_q;
                  merge_rst_q <= 1'b1;
                  busy_q      <= 1'b0;
               end
`ifdef MERGE_RO_TIMEOUT_EN
               else if (run_cnt_q == RC_W'(MAX_CYCLES - 1)) begin
                  state_q     <= DONE;
                  done_q      <= 1'b1;
                  timeout_q   <= 1'b1;
                  bx_done_q   <= bx_reg_q;
                  merge_rst_q <= 1'b1;
                  busy_q      <= 1'b0;
               end else begin
                  run_cnt_q <= run_cnt_q + RC_W'(1);
               end
`endif
            end
            default: begin
               state_q     <= IDLE;
               merge_rst_q <= 1'b1;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign merge_rst    = merge_rst_q;
   assign page_out     = page_q;
   assign expected     = expected_q;
   assign word_cnt     = word_cnt_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign bx_done      = bx_done_q;
   assign timeout      = timeout_q;
   assign missed_start = missed_q;

endmodule

// File: tb/tb_merge_readout_ctrl.sv
// Bench for merge_readout_ctrl: window-level reference model checked every cycle plus directed literal checks.
module tb_merge_readout_ctrl;
   localparam int PAGE_BITS = 2;
   localparam int FC        = 2;
   localparam int MAXC      = 100;
   localparam int CW        = 6;
`ifdef MERGE_RO_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              bx_start = 1'b0;
   logic [2:0]        bx_in = '0;
   logic [8*CW-1:0]   number_in = '0;
   logic              valid_out = 1'b0;
   logic              merge_rst;
   logic [PAGE_BITS-1:0] page_out;
   logic [CW+2:0]     expected;
   logic [CW+2:0]     word_cnt;
   logic              busy;
   logic              done;
   logic [2:0]        bx_done;
   logic              timeout;
   logic              missed_start;

   merge_readout_ctrl #(
      .PAGE_BITS(PAGE_BITS), .FLUSH_CYCLES(FC), .MAX_CYCLES(MAXC), .CNT_WIDTH(CW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bx_start(bx_start), .bx_in(bx_in),
      .number_in(number_in), .valid_out(valid_out), .merge_rst(merge_rst),
      .page_out(page_out), .expected(expected), .word_cnt(word_cnt), .busy(busy),
      .done(done), .bx_done(bx_done), .timeout(timeout), .missed_start(missed_start)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int fails  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Window-level model: a crossing is a window opened at its accept edge; everything
   // else is derived from the number of edges elapsed since then.
   int cyc = 0;
   bit started = 1'b0;
   bit m_win = 1'b0;
   int m_t = 0;
   int m_exp = 0, m_cnt = 0, m_bx = 0, m_page = 0, m_bxd = 0;
   bit e_done = 1'b0, e_to = 1'b0, e_miss = 1'b0, e_busy = 1'b0, e_mrst = 1'b1;

   function automatic int occ_total(input logic [8*CW-1:0] v);
      int s;
      s = 0;
      for (int k = 0; k < 8; k++) s += int'(v[k*CW +: CW]);
      return s;
   endfunction

   always @(posedge clk) begin
      int off;
      cyc++;
      started = 1'b1;
      e_done = 1'b0; e_to = 1'b0; e_miss = 1'b0;
      if (!rst_n) begin
         m_win = 1'b0; m_exp = 0; m_cnt = 0; m_page = 0; m_bxd = 0;
      end else if (m_win) begin
         off = cyc - m_t;
         if (bx_start) e_miss = 1'b1;
         if (off == FC) begin
            m_exp = occ_total(number_in);
            if (m_exp == 0) begin m_win = 1'b0; e_done = 1'b1; m_bxd = m_bx; end
         end else if (off > FC) begin
            if (valid_out) m_cnt++;
            if (m_cnt == m_exp) begin
               m_win = 1'b0; e_done = 1'b1; m_bxd = m_bx;
            end else if (TO_EN && off == FC + MAXC) begin
               m_win = 1'b0; e_done = 1'b1; e_to = 1'b1; m_bxd = m_bx;
            end
         end
      end else if (bx_start) begin
         m_win = 1'b1; m_t = cyc; m_bx = int'(bx_in);
         m_page = int'(bx_in) % (1 << PAGE_BITS); m_cnt = 0;
      end
      e_busy = m_win;
      e_mrst = !(m_win && (cyc - m_t) >= FC);
   end

   always @(negedge clk) begin
      if (started) begin
         chk("merge_rst", merge_rst, e_mrst);
         chk("busy", busy, e_busy);
         chk("done", done, e_done);
         chk("timeout", timeout, e_to);
         chk("missed_start", missed_start, e_miss);
         chk("page_out", page_out, m_page);
         chk("expected", expected, m_exp);
         chk("word_cnt", word_cnt, m_cnt);
         if (e_done) chk("bx_done", bx_done, m_bxd);
      end
   end

   task automatic cyc_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic start_bx(input logic [2:0] b, input logic [8*CW-1:0] occ);
      bx_in = b; number_in = occ; bx_start = 1'b1;
      @(negedge clk);
      bx_start = 1'b0;
   endtask

   task automatic pulse_valid(input int n);
      valid_out = 1'b1;
      cyc_n(n);
      valid_out = 1'b0;
   endtask

   task automatic wait_run(input string name, input int budget);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (merge_rst === 1'b0) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      chk(name, ok, 1'b1);
   endtask

   task automatic wait_done(input int budget, output int k);
      k = 0;
      while (done !== 1'b1 && k < budget) begin
         @(negedge clk);
         k++;
      end
   endtask

   initial begin
      int k;
      cyc_n(3);
      rst_n = 1'b1;
      cyc_n(10);
      chk("idle_merge_rst", merge_rst, 1);
      chk("idle_busy", busy, 0);
      chk("idle_word_cnt", word_cnt, 0);
      chk("idle_expected", expected, 0);
      chk("idle_page", page_out, 0);
      chk("idle_bx_done", bx_done, 0);

      // Occupancies {3,0,1,0,0,2,0,0}, input 0 in the low field.
      start_bx(3'd5, {6'd0, 6'd0, 6'd2, 6'd0, 6'd0, 6'd1, 6'd0, 6'd3});
      chk("A_page", page_out, 1);
      chk("A_busy", busy, 1);
      valid_out = 1'b1;
      cyc_n(1);
      valid_out = 1'b0;
      wait_run("A_run", 10);
      pulse_valid(3);
      cyc_n(2);
      pulse_valid(3);
      chk("A_done", done, 1);
      chk("A_bx_done", bx_done, 5);
      chk("A_expected", expected, 6);
      chk("A_word_cnt", word_cnt, 6);
      chk("A_timeout", timeout, 0);
      cyc_n(1);
      chk("A_done_once", done, 0);
      chk("A_merge_rst_back", merge_rst, 1);

      cyc_n(3);
      start_bx(3'd2, '0);
      chk("B_no_done_early", done, 0);
      cyc_n(FC - 1);
      chk("B_no_done_flush", done, 0);
      cyc_n(1);
      chk("B_done", done, 1);
      chk("B_merge_rst", merge_rst, 1);
      chk("B_bx_done", bx_done, 2);
      chk("B_expected", expected, 0);

      cyc_n(2);
      start_bx(3'd6, {6'd4, 42'd0});
      wait_run("C_run", 10);
      pulse_valid(2);
      bx_start = 1'b1;
      cyc_n(1);
      bx_start = 1'b0;
      chk("C_missed", missed_start, 1);
      chk("C_busy_kept", busy, 1);
      pulse_valid(2);
      chk("C_done", done, 1);
      chk("C_bx_done", bx_done, 6);
      start_bx(3'd3, {36'd0, 6'd2, 6'd0});
      chk("C_back_to_back_busy", busy, 1);
      chk("C_back_to_back_no_miss", missed_start, 0);
      chk("C_page", page_out, 3);
      wait_run("C2_run", 10);
      pulse_valid(2);
      chk("C2_done", done, 1);
      chk("C2_bx_done", bx_done, 3);

      cyc_n(2);
      start_bx(3'd1, {24'd0, 6'd10, 18'd0});
      wait_run("D_run", 10);
      pulse_valid(4);
`ifdef MERGE_RO_TIMEOUT_EN
      wait_done(150, k);
      chk("D_done_seen", done, 1);
      chk("D_timeout_latency", 4 + k, MAXC);
      chk("D_timeout", timeout, 1);
      chk("D_word_cnt", word_cnt, 4);
`else
      cyc_n(150);
      chk("D_busy_hold", busy, 1);
      chk("D_merge_rst_low", merge_rst, 0);
      chk("D_word_cnt", word_cnt, 4);
      rst_n = 1'b0;
      cyc_n(1);
      rst_n = 1'b1;
      chk("D_reset_busy", busy, 0);
      wait_done(0, k);
`endif

      cyc_n(2);
      start_bx(3'd7, {42'd0, 6'd5});
      wait_run("E_run", 10);
      pulse_valid(3);
      chk("E_word_cnt_pre", word_cnt, 3);
      rst_n = 1'b0;
      cyc_n(1);
      rst_n = 1'b1;
      chk("E_word_cnt", word_cnt, 0);
      chk("E_merge_rst", merge_rst, 1);
      chk("E_busy", busy, 0);
      chk("E_done", done, 0);
      chk("E_page", page_out, 0);
      cyc_n(6);
      chk("E_no_done_later", done, 0);

      $display("[TB] %0d tests run, %0d failed", checks, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d checks so far", checks);
      $fatal(1);
   end

endmodule
